// File: rtl/mxint_dequant_stream.sv
// mxint_dequant_stream: turns one MxInt block (shared exponent + mantissas) into
// OUT_PARALLELISM-wide beats of saturated signed fixed-point values.
module mxint_dequant_stream #(
  parameter int MAN_WIDTH       = 8,
  parameter int EXP_WIDTH       = 8,
  parameter int BLOCK_SIZE      = 4,
  parameter int OUT_PARALLELISM = 2,
  parameter int OUT_WIDTH       = 16,
  parameter int OUT_FRAC_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE],
  input  logic [EXP_WIDTH-1:0]        edata_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out [OUT_PARALLELISM],
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic                        data_out_last
);
  localparam int NBEATS = BLOCK_SIZE / OUT_PARALLELISM;
  localparam int CW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam int SW = EXP_WIDTH + $clog2(MAN_WIDTH + OUT_FRAC_WIDTH + 2) + 2;
  localparam int EBIAS = 2 ** (EXP_WIDTH - 1) - 1;
  localparam int WW = MAN_WIDTH + OUT_WIDTH;
  localparam logic signed [SW-1:0] SOFF = SW'(OUT_FRAC_WIDTH - EBIAS - (MAN_WIDTH - 2));
  localparam logic signed [SW-1:0] SLIM = SW'(OUT_WIDTH);
  localparam logic signed [WW-1:0] SMAX = WW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [WW-1:0] SMIN = -SMAX;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state, state_n;
  logic [CW-1:0]               count, count_n;
  logic signed [MAN_WIDTH-1:0] man [BLOCK_SIZE];
  logic signed [SW-1:0]        shift;
  logic                        last, adv, load;

  // Left shifts below OUT_WIDTH fit in WW bits; anything larger is saturated outright.
  function automatic logic signed [OUT_WIDTH-1:0] conv(input logic signed [MAN_WIDTH-1:0] m,
                                                       input logic signed [SW-1:0] s);
    logic signed [WW-1:0] w;
    logic big, sat_p, sat_n;
    w = {{OUT_WIDTH{m[MAN_WIDTH-1]}}, m};
    w = s[SW-1] ? w >>> (-s) : w <<< s;
    big = !s[SW-1] && s >= SLIM;
    sat_p = !m[MAN_WIDTH-1] && m != '0 && (big || w > SMAX);
    sat_n = m[MAN_WIDTH-1] && (big || w < SMIN);
    return sat_p ? SMAX[OUT_WIDTH-1:0] : sat_n ? SMIN[OUT_WIDTH-1:0] : w[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    last = count == CW'(NBEATS - 1);
    adv = state == BUSY && data_out_ready;
    data_in_ready = rst && (state == IDLE || (adv && last));
    load = data_in_valid && data_in_ready;
    state_n = load ? BUSY : (adv && last) ? IDLE : state;
    count_n = (load || (adv && last)) ? '0 : adv ? count + CW'(1) : count;
    data_out_valid = state == BUSY;
    data_out_last = data_out_valid && last;
    for (int j = 0; j < OUT_PARALLELISM; j++)
      data_out[j] = conv(man[int'(count) * OUT_PARALLELISM + j], shift);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      shift <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) man[i] <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (load) begin
        man <= mdata_in;
        shift <= $signed({{(SW - EXP_WIDTH){1'b0}}, edata_in}) + SOFF;
      end
    end
  end
endmodule

// File: tb/tb_mxint_dequant_stream.sv
// tb_mxint_dequant_stream: random and directed MxInt blocks, scoreboarded against an
// arithmetic reference of the dequantisation rules.
module tb_mxint_dequant_stream;
  localparam int MW = 8, EW = 8, BS = 4, OP = 2, OW = 16, OFW = 8, NB = BS / OP;

  typedef struct packed {
    logic               last;
    logic [OP-1:0][OW-1:0] d;
  } beat_t;

  logic                 clk = 0, rst = 0;
  logic signed [MW-1:0] mdata_in [BS];
  logic [EW-1:0]        edata_in = '0;
  logic                 data_in_valid = 0, data_in_ready;
  logic signed [OW-1:0] data_out [OP];
  logic                 data_out_valid, data_out_ready = 1, data_out_last;

  int    checks = 0, failures = 0;
  int    stall_pct = 0, cyc = 0, beats = 0;
  int    b2b = 0, b2b_beats = 0, b2b_first = -1, b2b_last = -1;
  beat_t q[$];
  beat_t held;
  logic  stall_prev = 0;

  mxint_dequant_stream #(.MAN_WIDTH(MW), .EXP_WIDTH(EW), .BLOCK_SIZE(BS),
    .OUT_PARALLELISM(OP), .OUT_WIDTH(OW), .OUT_FRAC_WIDTH(OFW)) dut (
    .clk(clk), .rst(rst), .mdata_in(mdata_in), .edata_in(edata_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_last(data_out_last));

  always #5 clk = ~clk;

  function automatic int ref_conv(int m, int e);
    int s, n, mx;
    longint v, p;
    s = e - (2 ** (EW - 1) - 1) - (MW - 2) + OFW;
    mx = 2 ** (OW - 1) - 1;
    if (m == 0) return 0;
    if (s >= 0) begin
      v = (s > 40) ? ((m > 0) ? mx + 1 : -mx - 1) : longint'(m) * (longint'(1) << s);
    end else begin
      n = -s;
      if (n >= MW) return (m < 0) ? -1 : 0;
      p = longint'(1) << n;
      v = (m >= 0) ? m / p : -((-m + p - 1) / p);
    end
    if (v > mx) v = mx;
    if (v < -mx) v = -mx;
    return int'(v);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.last = data_out_last;
    for (int j = 0; j < OP; j++) b.d[j] = data_out[j];
    return b;
  endfunction

  task automatic send(input int m[BS], input int e);
    int waited = 0;
    beat_t b;
    data_in_valid = 1;
    for (int i = 0; i < BS; i++) mdata_in[i] = MW'(m[i]);
    edata_in = EW'(e);
    forever begin
      @(negedge clk);
      if (data_in_ready) break;
      if (++waited > 200) begin
        chk("send_timeout", 0, 1);
        data_in_valid = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < NB; k++) begin
      b.last = (k == NB - 1);
      for (int j = 0; j < OP; j++) b.d[j] = OW'(ref_conv(m[k * OP + j], e));
      q.push_back(b);
    end
    @(posedge clk);
    #1;
    data_in_valid = 0;
  endtask

  task automatic rand_block(output int m[BS], output int e);
    for (int i = 0; i < BS; i++)
      m[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
    e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(105, 145));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #1;
    data_out_ready = ($urandom_range(0, 99) >= stall_pct);
  end

  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (stall_prev) begin
        chk("stall_valid", data_out_valid, 1);
        chk("stall_hold", cur_beat(), held);
      end
      if (data_out_valid) chk("in_ready_busy", data_in_ready, data_out_last && data_out_ready);
      else chk("in_ready_idle", data_in_ready, 1);
      if (data_out_valid && data_out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = q.pop_front();
          for (int j = 0; j < OP; j++) chk($sformatf("lane%0d", j), data_out[j], $signed(e.d[j]));
          chk("last", data_out_last, e.last);
        end
        beats++;
        if (b2b != 0) begin
          b2b_beats++;
          if (b2b_first < 0) b2b_first = cyc;
          b2b_last = cyc;
        end
      end
      stall_prev = data_out_valid && !data_out_ready;
      held = cur_beat();
    end else stall_prev = 0;
  end

  initial begin
    int dm [6][BS];
    int de [6];
    int m [BS];
    int e, nb, n;
    dm = '{'{64, -3, 0, 1}, '{40, -1, -40, 7}, '{5, -5, 0, 127},
           '{1, -1, -128, 0}, '{1, -1, 2, 0}, '{-128, 127, -1, 1}};
    de = '{127, 120, 100, 140, 139, 125};
    for (int i = 0; i < BS; i++) mdata_in[i] = '0;
    #12;
    chk("rst_valid", data_out_valid, 0);
    chk("rst_last", data_out_last, 0);
    chk("rst_in_ready", data_in_ready, 0);
    chk("rst_lane0", data_out[0], 0);
    chk("rst_lane1", data_out[1], 0);
    #10 rst = 1;
    @(posedge clk);
    #1;
    chk("idle_valid", data_out_valid, 0);
    chk("idle_in_ready", data_in_ready, 1);

    send(dm[0], de[0]);
    chk("latency_valid", data_out_valid, 1);
    drain();
    for (int t = 1; t < 6; t++) begin
      send(dm[t], de[t]);
      drain();
    end

    b2b = 1;
    for (int t = 0; t < 8; t++) begin
      rand_block(m, e);
      send(m, e);
    end
    drain();
    b2b = 0;
    chk("b2b_beats", b2b_beats, 8 * NB);
    chk("b2b_no_bubble", b2b_last - b2b_first + 1, b2b_beats);

    stall_pct = 40;
    for (int t = 0; t < 40; t++) begin
      rand_block(m, e);
      send(m, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    stall_pct = 0;
    rand_block(m, e);
    nb = beats;
    send(m, e);
    n = 0;
    while (beats == nb && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_beat0_seen", beats - nb, 1);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("mid_rst_valid", data_out_valid, 0);
    chk("mid_rst_last", data_out_last, 0);
    chk("mid_rst_in_ready", data_in_ready, 0);
    chk("mid_rst_lane0", data_out[0], 0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1;
    @(negedge clk);
    chk("post_rst_valid", data_out_valid, 0);
    chk("post_rst_in_ready", data_in_ready, 1);
    @(posedge clk);
    #1;
    rand_block(m, e);
    send(m, e);
    drain();
    for (int t = 0; t < 3; t++) begin
      rand_block(m, e);
      send(m, e);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=<500000", $time);
    $fatal(1);
  end
endmodule
